// File: rtl/spi_slave_frame_if.sv
// SPI pins plus receive handshake for spi_slave_frame.
// crc_err exists only when SPI_CRC8_EN is defined.
interface spi_slave_frame_if #(
    parameter int RX_W = 88,
    parameter int TX_W = 40
);
    logic            sck;
    logic            ssel_n;
    logic            mosi;
    logic            miso;
    logic [TX_W-1:0] tx_data;
    logic [RX_W-1:0] rx_data;
    logic            rx_valid;
    logic            rx_len_err;
    logic            busy;
    logic [7:0]      bit_cnt;
`ifdef SPI_CRC8_EN
    logic            crc_err;

    modport slave (
        input  sck, ssel_n, mosi, tx_data,
        output miso, rx_data, rx_valid, rx_len_err, busy, bit_cnt, crc_err
    );
    modport master (
        output sck, ssel_n, mosi, tx_data,
        input  miso, rx_data, rx_valid, rx_len_err, busy, bit_cnt, crc_err
    );
`else
    modport slave (
        input  sck, ssel_n, mosi, tx_data,
        output miso, rx_data, rx_valid, rx_len_err, busy, bit_cnt
    );
    modport master (
        output sck, ssel_n, mosi, tx_data,
        input  miso, rx_data, rx_valid, rx_len_err, busy, bit_cnt
    );
`endif
endinterface

// File: rtl/spi_slave_frame.sv
// Oversampled SPI slave: fixed-length RX frame with length check, TX word after a bit offset.
// Define SPI_CRC8_EN to check a trailing CRC-8 (poly 0x07) and expose crc_err.
module spi_slave_frame #(
    parameter int RX_W      = 88,
    parameter int TX_W      = 40,
    parameter int TX_OFFSET = 88,
    parameter bit CPOL      = 1'b0,
    parameter bit CPHA      = 1'b0,
    parameter bit LSB_FIRST = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    spi_slave_frame_if.slave  bus
);
    localparam bit         SAMPLE_RISE = ((CPOL ^ CPHA) == 1'b0);
    localparam bit         PRELOAD     = (CPHA == 1'b0) && (TX_OFFSET == 0);
    localparam logic [7:0] RX_LEN      = 8'(RX_W);
    localparam logic [7:0] TX_START    = 8'(TX_OFFSET);
    localparam logic [8:0] TX_LEN      = 9'(TX_W);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

    state_t          r_state;
    logic [2:0]      r_sck_sync;
    logic [2:0]      r_ssel_sync;
    logic [2:0]      r_mosi_sync;
    logic            r_live;
    logic            r_armed;
    logic [RX_W-1:0] r_rx_shift;
    logic [TX_W-1:0] r_tx_shift;
    logic [8:0]      r_tx_idx;
    logic            r_tx_on;
    logic [7:0]      r_bit_cnt;
    logic            r_miso;
    logic [RX_W-1:0] r_rx_data;
    logic            r_rx_valid;
    logic            r_len_err;
    logic            r_busy;

    logic            w_sck_rise;
    logic            w_sck_fall;
    logic            w_sample;
    logic            w_shift;
    logic            w_ssel_fall;
    logic            w_ssel_rise;
    logic            w_mosi;
    logic [7:0]      w_cnt_next;
    logic [RX_W-1:0] w_rx_next;

    function automatic logic [TX_W-1:0] tx_advance(input logic [TX_W-1:0] v);
        return LSB_FIRST ? (v >> 1) : (v << 1);
    endfunction

    function automatic logic tx_head(input logic [TX_W-1:0] v);
        return LSB_FIRST ? v[0] : v[TX_W-1];
    endfunction

`ifdef SPI_CRC8_EN
    localparam logic [7:0] CRC_LEN = 8'(RX_W - 8);

    logic       r_crc;
    logic [7:0] r_crc_acc;
    logic [7:0] w_crc_rx;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    // The CRC byte arrives in the same bit order as the payload.
    assign w_crc_rx   = LSB_FIRST ? r_rx_shift[RX_W-1 -: 8] : r_rx_shift[7:0];
    assign bus.crc_err = r_crc;
`endif

    assign w_sck_rise  = r_sck_sync[1] & ~r_sck_sync[2];
    assign w_sck_fall  = ~r_sck_sync[1] & r_sck_sync[2];
    assign w_sample    = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
    assign w_shift     = SAMPLE_RISE ? w_sck_fall : w_sck_rise;
    assign w_ssel_fall = r_ssel_sync[2] & ~r_ssel_sync[1];
    assign w_ssel_rise = ~r_ssel_sync[2] & r_ssel_sync[1];
    assign w_mosi      = r_mosi_sync[1];
    assign w_cnt_next  = (r_bit_cnt == 8'hFF) ? r_bit_cnt : r_bit_cnt + 8'd1;

    always_comb begin
        w_rx_next = '0;
        if (LSB_FIRST) begin
            w_rx_next         = r_rx_shift >> 1;
            w_rx_next[RX_W-1] = w_mosi;
        end else begin
            w_rx_next    = r_rx_shift << 1;
            w_rx_next[0] = w_mosi;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sck_sync  <= {3{CPOL}};
            r_ssel_sync <= 3'b111;
            r_mosi_sync <= 3'b000;
        end else begin
            r_sck_sync  <= {r_sck_sync[1:0], bus.sck};
            r_ssel_sync <= {r_ssel_sync[1:0], bus.ssel_n};
            r_mosi_sync <= {r_mosi_sync[1:0], bus.mosi};
        end
    end

    // The sync reset value fakes ssel high; only arm once the real pin has been seen high,
    // so a frame already in progress at reset release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (r_live && r_ssel_sync[0]) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_rx_shift <= '0;
            r_tx_shift <= '0;
            r_tx_idx   <= '0;
            r_tx_on    <= 1'b0;
            r_bit_cnt  <= '0;
            r_miso     <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_len_err  <= 1'b0;
            r_busy     <= 1'b0;
`ifdef SPI_CRC8_EN
            r_crc      <= 1'b0;
            r_crc_acc  <= '0;
`endif
        end else begin
            r_rx_valid <= 1'b0;
            r_len_err  <= 1'b0;
`ifdef SPI_CRC8_EN
            r_crc      <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_ssel_fall && r_armed) begin
                        r_state    <= ACTIVE;
                        r_bit_cnt  <= '0;
                        r_rx_shift <= '0;
                        r_busy     <= 1'b1;
                        r_tx_on    <= (TX_OFFSET == 0);
`ifdef SPI_CRC8_EN
                        r_crc_acc  <= '0;
`endif
                        // With CPHA=0 the first bit must be on the wire before the first edge.
                        if (PRELOAD) begin
                            r_miso     <= tx_head(bus.tx_data);
                            r_tx_shift <= tx_advance(bus.tx_data);
                            r_tx_idx   <= 9'd1;
                        end else begin
                            r_miso     <= 1'b0;
                            r_tx_shift <= bus.tx_data;
                            r_tx_idx   <= 9'd0;
                        end
                    end
                end
                ACTIVE: begin
                    if (w_ssel_rise) begin
                        r_state <= DONE;
                    end else begin
                        if (w_sample) begin
                            r_rx_shift <= w_rx_next;
                            r_bit_cnt  <= w_cnt_next;
                            if (w_cnt_next == TX_START) begin
                                r_tx_on <= 1'b1;
                            end
`ifdef SPI_CRC8_EN
                            if (r_bit_cnt < CRC_LEN) begin
                                r_crc_acc <= crc8_step(r_crc_acc, w_mosi);
                            end
`endif
                        end
                        if (w_shift && r_tx_on) begin
                            if (r_tx_idx < TX_LEN) begin
                                r_miso     <= tx_head(r_tx_shift);
                                r_tx_shift <= tx_advance(r_tx_shift);
                                r_tx_idx   <= r_tx_idx + 9'd1;
                            end else begin
                                r_miso <= 1'b0;
                            end
                        end
                    end
                end
                DONE: begin
                    if (r_bit_cnt == RX_LEN) begin
`ifdef SPI_CRC8_EN
                        if (w_crc_rx == r_crc_acc) begin
                            r_rx_data  <= r_rx_shift;
                            r_rx_valid <= 1'b1;
                        end else begin
                            r_crc <= 1'b1;
                        end
`else
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
`endif
                    end else begin
                        r_len_err <= 1'b1;
                    end
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_miso  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.miso       = r_miso;
    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.rx_len_err = r_len_err;
    assign bus.busy       = r_busy;
    assign bus.bit_cnt    = r_bit_cnt;
endmodule

// File: tb/tb_spi_slave_frame.sv
// Bench for spi_slave_frame: three parameterisations driven by one bit-banged SPI master,
// receive pulses checked against a queue of expected events.
module tb_spi_slave_frame;
    localparam int H = 50;
    localparam int RXW [3] = '{88, 16, 16};

    typedef struct {
        int           dut;
        int           kind;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   sel;
    logic m_sck, m_ssel_n, m_mosi, m_miso;
    logic [39:0] tx_a;
    logic [15:0] tx_b, tx_c;
    int   total = 0;
    int   bad = 0;
    exp_t sb [$];
    logic [127:0] held [3];

    always #5 clk = ~clk;

    spi_slave_frame_if #(.RX_W(88), .TX_W(40)) ifa ();
    spi_slave_frame_if #(.RX_W(16), .TX_W(16)) ifb ();
    spi_slave_frame_if #(.RX_W(16), .TX_W(16)) ifc ();

    spi_slave_frame #(.RX_W(88), .TX_W(40), .TX_OFFSET(88), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0))
        dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
    spi_slave_frame #(.RX_W(16), .TX_W(16), .TX_OFFSET(0), .CPOL(1'b1), .CPHA(1'b1), .LSB_FIRST(1'b1))
        dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));
    spi_slave_frame #(.RX_W(16), .TX_W(16), .TX_OFFSET(0), .CPOL(1'b0), .CPHA(1'b0), .LSB_FIRST(1'b0))
        dut_c (.clk(clk), .rst_n(rst_c), .bus(ifc));

    assign ifa.sck     = (sel == 0) ? m_sck : 1'b0;
    assign ifb.sck     = (sel == 1) ? m_sck : 1'b1;
    assign ifc.sck     = (sel == 2) ? m_sck : 1'b0;
    assign ifa.ssel_n  = (sel == 0) ? m_ssel_n : 1'b1;
    assign ifb.ssel_n  = (sel == 1) ? m_ssel_n : 1'b1;
    assign ifc.ssel_n  = (sel == 2) ? m_ssel_n : 1'b1;
    assign ifa.mosi    = m_mosi;
    assign ifb.mosi    = m_mosi;
    assign ifc.mosi    = m_mosi;
    assign ifa.tx_data = tx_a;
    assign ifb.tx_data = tx_b;
    assign ifc.tx_data = tx_c;
    assign m_miso = (sel == 0) ? ifa.miso : (sel == 1) ? ifb.miso : ifc.miso;

    logic [2:0] w_valid, w_len, w_crc, w_busy, w_evt;
    logic [127:0] rd [3];
    assign w_valid = {ifc.rx_valid, ifb.rx_valid, ifa.rx_valid};
    assign w_len   = {ifc.rx_len_err, ifb.rx_len_err, ifa.rx_len_err};
    assign w_busy  = {ifc.busy, ifb.busy, ifa.busy};
`ifdef SPI_CRC8_EN
    assign w_crc   = {ifc.crc_err, ifb.crc_err, ifa.crc_err};
`else
    assign w_crc   = 3'b000;
`endif
    assign w_evt   = w_valid | w_len | w_crc;
    assign rd[0]   = 128'(ifa.rx_data);
    assign rd[1]   = 128'(ifb.rx_data);
    assign rd[2]   = 128'(ifc.rx_data);

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

`ifdef SPI_CRC8_EN
    // Reference CRC-8 over all but the last 8 bits in wire order; last 8 bits form the byte.
    function automatic int crc_kind(input int n, input bit lsb, input logic [127:0] din);
        logic [7:0] c;
        logic [7:0] rx;
        logic       b;
        c = 8'h00;
        rx = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = lsb ? din[i] : din[n-1-i];
            if (i < n - 8) c = (c[7] ^ b) ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
            else rx = lsb ? {b, rx[7:1]} : {rx[6:0], b};
        end
        return (c == rx) ? 1 : 3;
    endfunction
`endif

    task automatic do_evt(input int evt);
        if (evt == 1) begin
            rst_c = 1'b0;
            #20;
            check("rst_busy", ifc.busy, 1'b0);
            check("rst_miso", ifc.miso, 1'b0);
            check("rst_rxdata", rd[2], 128'h0);
            held[2] = '0;
            rst_c = 1'b1;
        end else if (evt == 2) begin
            tx_c = 16'hFFFF;
        end
    endtask

    task automatic xfer(input int d, input int n, input logic [127:0] din, input int evt_at,
                        input int evt, output logic [127:0] dout, output int lat);
        bit cpol, cpha, lsb;
        cpol = (d == 1);
        cpha = cpol;
        lsb  = cpol;
        dout = '0;
        lat  = 0;
        m_sck = cpol;
        sel = d;
        m_mosi = 1'b0;
        @(posedge clk); #1;
        m_ssel_n = 1'b0;
        if (!cpha && n > 0) m_mosi = din[lsb ? 0 : n-1];
        #100;
        check("busy_on", w_busy[d], 1'b1);
        for (int i = 0; i < n; i++) begin
            if (i == evt_at) do_evt(evt);
            m_sck = ~cpol;
            if (!cpha) dout[lsb ? i : n-1-i] = m_miso;
            else m_mosi = din[lsb ? i : n-1-i];
            #(H);
            m_sck = cpol;
            if (cpha) dout[lsb ? i : n-1-i] = m_miso;
            else if (i + 1 < n) m_mosi = din[lsb ? i+1 : n-2-i];
            #(H);
        end
        if (evt == 1) begin
            check("rst_busy_rem", w_busy[d], 1'b0);
            check("rst_miso_rem", m_miso, 1'b0);
        end
        @(posedge clk); #1;
        m_ssel_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && w_evt[d]) lat = k;
        end
        check("busy_off", w_busy[d], 1'b0);
    endtask

    task automatic run(input string nm, input int d, input int n, input logic [127:0] din,
                       input int evt_at, input int evt, input int force_kind, input logic [127:0] exp_rd);
        logic [127:0] dout;
        int   lat;
        int   kind;
        exp_t e;
        if (evt != 1) begin
            if (force_kind != 0) kind = force_kind;
            else if (n != RXW[d]) kind = 2;
`ifdef SPI_CRC8_EN
            else kind = crc_kind(n, d == 1, din);
`else
            else kind = 1;
`endif
            if (kind == 1) held[d] = din;
            e.dut  = d;
            e.kind = kind;
            e.data = held[d];
            sb.push_back(e);
        end
        xfer(d, n, din, evt_at, evt, dout, lat);
        check({nm, "_miso"}, dout, exp_rd);
        check({nm, "_lat"}, lat, (evt == 1) ? 0 : 4);
    endtask

    // Monitor: every receive pulse must match the next queued expectation.
    initial begin
        exp_t e;
        int   k;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                k = w_valid[d] ? 1 : w_len[d] ? 2 : w_crc[d] ? 3 : 0;
                if (k != 0) begin
                    if (sb.size() == 0) begin
                        check("unexpected_evt", k, 0);
                    end else begin
                        e = sb.pop_front();
                        check("sb_dut", d, e.dut);
                        check("sb_kind", k, e.kind);
                        check("sb_rxdata", rd[d], e.data);
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] pat;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        sel = 0; m_sck = 1'b0; m_ssel_n = 1'b1; m_mosi = 1'b0;
        tx_a = 40'h12_3456_789A; tx_b = 16'hC3A5; tx_c = 16'h5AC3;
        for (int d = 0; d < 3; d++) held[d] = '0;
        #25;
        check("rst_a_rxdata", rd[0], 128'h0);
        check("rst_a_busy", ifa.busy, 1'b0);
        check("rst_a_bitcnt", ifa.bit_cnt, 8'd0);
        check("rst_a_miso", ifa.miso, 1'b0);
        check("rst_b_miso", ifb.miso, 1'b0);
        check("rst_c_flags", {ifc.rx_valid, ifc.rx_len_err, ifc.busy}, 3'b000);
        @(posedge clk); #1;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        repeat (5) @(posedge clk);

        pat = '0;
        pat[87:0] = {11{8'hA5}};
        run("a_ok", 0, 88, pat, -1, 0, 0, 128'h0);
        check("a_bitcnt88", ifa.bit_cnt, 8'd88);
        run("a_long", 0, 128, pat << 40, -1, 0, 0, 128'h12_3456_789A);
        check("a_bitcnt128", ifa.bit_cnt, 8'd128);

        run("b_mode3", 1, 16, 128'h8001, -1, 0, 0, 128'hC3A5);

        run("c_ok", 2, 16, 128'h1234, -1, 0, 0, 128'h5AC3);
        run("c_short", 2, 15, 128'h1234, -1, 0, 0, 128'h2D61);
        check("c_bitcnt15", ifc.bit_cnt, 8'd15);
        run("c_zero", 2, 0, 128'h0, -1, 0, 0, 128'h0);
        check("c_bitcnt0", ifc.bit_cnt, 8'd0);
        run("c_rst", 2, 16, 128'hFFFF, 7, 1, 0, 128'h5A00);
        run("c_after", 2, 16, 128'hBEEF, -1, 0, 0, 128'h5AC3);
        run("c_txchg", 2, 16, 128'h0F0F, 3, 2, 0, 128'h5AC3);
`ifdef SPI_CRC8_EN
        tx_c = 16'h0000;
        run("c_crc_ok", 2, 16, 128'h0107, -1, 0, 1, 128'h0);
        run("c_crc_bad", 2, 16, 128'h0108, -1, 0, 3, 128'h0);
`endif
        repeat (10) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
